vga_plot_arbiter: RTL and testbench

//  Shares the single VGA pixel-write port (plot, VGA_X, VGA_Y, VGA_COLOR) between pixel producers:

---
 rtl/pianissimo_vga_pkg.sv | 15 +
 rtl/vga_plot_arbiter_rr_pick.sv | 30 +++
 rtl/vga_plot_arbiter.sv | 144 ++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pianissimo_vga_pkg.sv
// rtl/pianissimo_vga_pkg.sv - shared VGA geometry constants and plot arbiter state encoding
package pianissimo_vga_pkg;

   localparam int X_W     = 8;
   localparam int Y_W     = 7;
   localparam int COLOR_W = 24;
   localparam int H_RES   = 160;
   localparam int V_RES   = 120;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_e;

endpackage

// File: rtl/vga_plot_arbiter_rr_pick.sv
// rtl/vga_plot_arbiter_rr_pick.sv - combinational round-robin picker, scans upward from last+1
module rr_pick #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] last_i,
   output logic [W-1:0] grant_o,
   output logic         any_o
);

   int           idx;
   logic [W-1:0] idx_w;

   always_comb begin
      grant_o = '0;
      any_o   = 1'b0;
      idx     = 0;
      idx_w   = '0;
      for (int off = 1; off <= N; off++) begin
         idx   = (int'(last_i) + off) % N;
         idx_w = W'(idx);
         if (!any_o && req_i[idx_w]) begin
            any_o   = 1'b1;
            grant_o = idx_w;
         end
      end
   end

endmodule

// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - burst-granular round-robin arbiter for the single VGA pixel-write port
module vga_plot_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int X_W       = pianissimo_vga_pkg::X_W,
   parameter int Y_W       = pianissimo_vga_pkg::Y_W,
   parameter int COLOR_W   = pianissimo_vga_pkg::COLOR_W,
   parameter int H_RES     = pianissimo_vga_pkg::H_RES,
   parameter int V_RES     = pianissimo_vga_pkg::V_RES,
   parameter int MAX_BURST = 19200
) (
   input  logic                       CLOCK_50,
   input  logic                       resetn,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_last,
   input  logic [NUM_REQ-1:0]         req_mask,
   input  logic [NUM_REQ*X_W-1:0]     req_x,
   input  logic [NUM_REQ*Y_W-1:0]     req_y,
   input  logic [NUM_REQ*COLOR_W-1:0] req_colour,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       plot,
   output logic [X_W-1:0]             VGA_X,
   output logic [Y_W-1:0]             VGA_Y,
   output logic [COLOR_W-1:0]         VGA_COLOR,
   output logic [2:0]                 owner,
   output logic                       busy,
   output logic                       timeout_pulse
);

   import pianissimo_vga_pkg::*;

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST);

   arb_state_e         state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d, last_owner_q, last_owner_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               plot_q, plot_d, timeout_q, timeout_d;
   logic [X_W-1:0]     x_q, x_d;
   logic [Y_W-1:0]     y_q, y_d;
   logic [COLOR_W-1:0] colour_q, colour_d;

   logic [NUM_REQ-1:0] elig;
   logic [IDX_W-1:0]   pick;
   logic               pick_any;
   logic [X_W-1:0]     sel_x;
   logic [Y_W-1:0]     sel_y;
   logic [COLOR_W-1:0] sel_colour;
   logic               sel_valid, sel_last, sel_mask, accept, at_limit;

   assign elig = req_valid & req_mask;

   rr_pick #(.N(NUM_REQ), .W(IDX_W)) u_pick (
      .req_i   (elig),
      .last_i  (last_owner_q),
      .grant_o (pick),
      .any_o   (pick_any)
   );

   // Only the owner's slice is ever looked at during a burst.
   assign sel_x      = req_x[owner_q*X_W +: X_W];
   assign sel_y      = req_y[owner_q*Y_W +: Y_W];
   assign sel_colour = req_colour[owner_q*COLOR_W +: COLOR_W];
   assign sel_valid  = req_valid[owner_q];
   assign sel_last   = req_last[owner_q];
   assign sel_mask   = req_mask[owner_q];
   assign accept     = (state_q == ARB_BURST) && sel_mask && sel_valid;
   assign at_limit   = (count_q == CNT_W'(MAX_BURST - 1));

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      count_d      = count_q;
      plot_d       = 1'b0;
      x_d          = x_q;
      y_d          = y_q;
      colour_d     = colour_q;
      timeout_d    = 1'b0;
      req_ready    = '0;
      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               state_d = ARB_BURST;
               owner_d = pick;
               count_d = '0;
            end
         end
         ARB_BURST: begin
            req_ready[owner_q] = sel_mask;
            if (!sel_mask) begin
               state_d      = ARB_IDLE;
               last_owner_d = owner_q;
            end else if (accept) begin
               x_d      = sel_x;
               y_d      = sel_y;
               colour_d = sel_colour;
               plot_d   = (int'(sel_x) < H_RES) && (int'(sel_y) < V_RES);
               // last wins over the limit, so a final beat at the cap is a normal end.
               if (sel_last || at_limit) begin
                  state_d      = ARB_IDLE;
                  last_owner_d = owner_q;
                  timeout_d    = !sel_last;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge resetn) begin
      if (resetn) begin
         state_q      <= ARB_IDLE;
         owner_q      <= '0;
         last_owner_q <= IDX_W'(NUM_REQ - 1);
         count_q      <= '0;
         plot_q       <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         colour_q     <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         count_q      <= count_d;
         plot_q       <= plot_d;
         x_q          <= x_d;
         y_q          <= y_d;
         colour_q     <= colour_d;
         timeout_q    <= timeout_d;
      end
   end

   assign plot          = plot_q;
   assign VGA_X         = x_q;
   assign VGA_Y         = y_q;
   assign VGA_COLOR     = colour_q;
   assign owner         = 3'(owner_q);
   assign busy          = (state_q == ARB_BURST);
   assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - directed self-checking bench for vga_plot_arbiter
module tb_vga_plot_arbiter;

   localparam int N  = 4;
   localparam int XW = 8;
   localparam int YW = 7;
   localparam int CW = 24;

   logic            CLOCK_50 = 1'b0;
   logic            resetn   = 1'b1;
   logic [N-1:0]    req_valid = '0, req_last = '0, req_mask = '0;
   logic [N*XW-1:0] req_x = '0;
   logic [N*YW-1:0] req_y = '0;
   logic [N*CW-1:0] req_colour = '0;
   logic [N-1:0]    req_ready;
   logic            plot, busy, timeout_pulse;
   logic [XW-1:0]   VGA_X;
   logic [YW-1:0]   VGA_Y;
   logic [CW-1:0]   VGA_COLOR;
   logic [2:0]      owner;

   int n_cmp = 0;
   int n_err = 0;
   int seq[5] = '{0, 1, 2, 3, 0};

   vga_plot_arbiter #(.NUM_REQ(N), .MAX_BURST(8)) dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn),
      .req_valid(req_valid), .req_last(req_last), .req_mask(req_mask),
      .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
      .req_ready(req_ready), .plot(plot), .VGA_X(VGA_X), .VGA_Y(VGA_Y),
      .VGA_COLOR(VGA_COLOR), .owner(owner), .busy(busy), .timeout_pulse(timeout_pulse)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_beat(input int i, input int x, input int y);
      req_x[i*XW +: XW]      = XW'(x);
      req_y[i*YW +: YW]      = YW'(y);
      req_colour[i*CW +: CW] = CW'(24'h404040 + i * 24'h010101);
   endtask

   task automatic do_reset();
      resetn = 1'b1;
      tick();
      tick();
      resetn = 1'b0;
   endtask

   initial begin
      tick();
      chk("rst_plot", 32'(plot), 0);
      chk("rst_x", 32'(VGA_X), 0);
      chk("rst_y", 32'(VGA_Y), 0);
      chk("rst_colour", 32'(VGA_COLOR), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_timeout", 32'(timeout_pulse), 0);
      chk("rst_ready", 32'(req_ready), 0);
      resetn = 1'b0;

      // 1: single three-beat burst from requester 0
      tick();
      req_mask = 4'b0001; req_valid = 4'b0001; set_beat(0, 10, 5);
      chk("t1_idle_ready", 32'(req_ready), 0);
      tick();
      chk("t1_busy", 32'(busy), 1);
      chk("t1_owner", 32'(owner), 0);
      chk("t1_ready", 32'(req_ready), 32'h1);
      chk("t1_noplot", 32'(plot), 0);
      tick();
      chk("t1_plot0", 32'(plot), 1);
      chk("t1_x0", 32'(VGA_X), 10);
      chk("t1_y0", 32'(VGA_Y), 5);
      set_beat(0, 11, 5);
      tick();
      chk("t1_plot1", 32'(plot), 1);
      chk("t1_x1", 32'(VGA_X), 11);
      set_beat(0, 12, 5); req_last = 4'b0001;
      tick();
      chk("t1_plot2", 32'(plot), 1);
      chk("t1_x2", 32'(VGA_X), 12);
      chk("t1_busy_end", 32'(busy), 0);
      req_valid = '0; req_last = '0;
      tick();
      chk("t1_plot_off", 32'(plot), 0);
      chk("t1_x_hold", 32'(VGA_X), 12);

      // 2: round robin over four single-beat bursts
      do_reset();
      req_mask = 4'b1111; req_valid = 4'b1111; req_last = 4'b1111;
      for (int i = 0; i < N; i++) set_beat(i, 20 + i, i);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t2_owner", 32'(owner), 32'(seq[k]));
         chk("t2_busy", 32'(busy), 1);
         chk("t2_ready", 32'(req_ready), 32'(1 << seq[k]));
         tick();
         chk("t2_idle", 32'(busy), 0);
         chk("t2_plot", 32'(plot), 1);
         chk("t2_x", 32'(VGA_X), 32'(20 + seq[k]));
         chk("t2_colour", 32'(VGA_COLOR), 32'(24'h404040 + seq[k] * 24'h010101));
         chk("t2_idle_ready", 32'(req_ready), 0);
      end
      req_valid = '0; req_last = '0;

      // 3: clipping (last_owner is 0, requester 0 still wins by wrap-around)
      req_mask = 4'b0001; req_valid = 4'b0001; set_beat(0, 160, 3);
      tick();
      chk("t3_owner", 32'(owner), 0);
      tick();
      chk("t3_clip_plot", 32'(plot), 0);
      chk("t3_clip_x", 32'(VGA_X), 160);
      chk("t3_clip_y", 32'(VGA_Y), 3);
      set_beat(0, 159, 119); req_last = 4'b0001;
      tick();
      chk("t3_edge_plot", 32'(plot), 1);
      chk("t3_edge_x", 32'(VGA_X), 159);
      chk("t3_edge_y", 32'(VGA_Y), 119);
      chk("t3_busy_end", 32'(busy), 0);
      req_valid = '0; req_last = '0;

      // 4: forced release after 8 beats from requester 1, requester 2 waiting
      req_mask = 4'b0110; req_valid = 4'b0110; set_beat(1, 40, 1); set_beat(2, 50, 2);
      tick();
      chk("t4_owner", 32'(owner), 1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t4_plot", 32'(plot), 1);
         chk("t4_x", 32'(VGA_X), 32'(40 + i));
         chk("t4_timeout", 32'(timeout_pulse), 32'(i == 7));
         chk("t4_busy", 32'(busy), 32'(i != 7));
         set_beat(1, 41 + i, 1);
      end
      tick();
      chk("t4_next_owner", 32'(owner), 2);
      chk("t4_next_busy", 32'(busy), 1);
      chk("t4_pulse_once", 32'(timeout_pulse), 0);
      chk("t4_dead_plot", 32'(plot), 0);

      // 5: mask drop after three beats from requester 2
      req_mask = 4'b0100; req_valid = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_plot", 32'(plot), 1);
         chk("t5_x", 32'(VGA_X), 32'(50 + i));
         set_beat(2, 51 + i, 2);
      end
      req_mask = 4'b0000;
      #1;
      chk("t5_ready_drop", 32'(req_ready), 0);
      chk("t5_still_busy", 32'(busy), 1);
      tick();
      chk("t5_no_plot", 32'(plot), 0);
      chk("t5_idle", 32'(busy), 0);
      chk("t5_no_timeout", 32'(timeout_pulse), 0);
      chk("t5_x_hold", 32'(VGA_X), 52);

      // 6: stall, then async reset mid-burst
      req_mask = 4'b0001; req_valid = 4'b0001; set_beat(0, 70, 9);
      tick();
      chk("t6_owner", 32'(owner), 0);
      tick();
      chk("t6_plot0", 32'(plot), 1);
      chk("t6_x0", 32'(VGA_X), 70);
      req_valid = 4'b0000;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("t6_stall_plot", 32'(plot), 0);
         chk("t6_stall_busy", 32'(busy), 1);
         chk("t6_stall_ready", 32'(req_ready), 32'h1);
      end
      req_valid = 4'b0001; set_beat(0, 71, 9);
      tick();
      chk("t6_plot1", 32'(plot), 1);
      chk("t6_x1", 32'(VGA_X), 71);
      req_mask = 4'b1001; req_valid = 4'b1001;
      #2 resetn = 1'b1;
      #1;
      chk("t6_ar_plot", 32'(plot), 0);
      chk("t6_ar_x", 32'(VGA_X), 0);
      chk("t6_ar_y", 32'(VGA_Y), 0);
      chk("t6_ar_colour", 32'(VGA_COLOR), 0);
      chk("t6_ar_busy", 32'(busy), 0);
      chk("t6_ar_ready", 32'(req_ready), 0);
      chk("t6_ar_timeout", 32'(timeout_pulse), 0);
      #1 resetn = 1'b0;
      tick();
      chk("t6_first_owner", 32'(owner), 0);
      chk("t6_first_busy", 32'(busy), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
